tb_sram_model_pipelined: RTL and testbench

Parametrised simulation model of the external asynchronous SRAM, replacing the fixed 16-bit, 2^18-word emulator in all testbenches. Runs on the design clock only, with no internal doubled clock, and adds:
- generic byte lanes
- a configurable read latency
- a sequential power-on clear engine
- access counters and a sticky error flag for bench self-checking

Sits in `tb/` between the DUT SRAM pins and the bench.

---
 rtl/tb_sram_pkg.sv | 14 +
 rtl/tb_sram_read_pipe.sv | 46 ++++
 rtl/tb_sram_model_pipelined.sv | 119 +++++++++++
 tb/tb_tb_sram_model_pipelined.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/tb_sram_pkg.sv
// Shared constants, state encoding and helpers for the pipelined SRAM simulation model.
package tb_sram_pkg;

  localparam int LANE_WIDTH       = 8;
  localparam int COUNT_WIDTH      = 32;
  localparam int READ_LATENCY_MAX = 4;

  typedef enum logic {S_CLEAR, S_READY} sram_state_t;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + COUNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/tb_sram_read_pipe.sv
// Read return delay line: DEPTH stages of {valid, lane mask, word}, one entry per cycle.
// Latency DEPTH cycles, never stalls; the head drops out of the last stage each edge.
module tb_sram_read_pipe
  import tb_sram_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int LANES = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_vld,
  input  logic [LANES-1:0]            i_mask,
  input  logic [LANES*LANE_WIDTH-1:0] i_dat,
  output logic                        o_vld,
  output logic [LANES-1:0]            o_mask,
  output logic [LANES*LANE_WIDTH-1:0] o_dat
);

  logic [DEPTH-1:0]            r_vld;
  logic [LANES-1:0]            r_mask [DEPTH];
  logic [LANES*LANE_WIDTH-1:0] r_dat  [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        r_mask[s] <= '0;
        r_dat[s]  <= '0;
      end
    end else begin
      r_vld[0]  <= i_vld;
      r_mask[0] <= i_mask;
      r_dat[0]  <= i_dat;
      for (int s = 1; s < DEPTH; s++) begin
        r_vld[s]  <= r_vld[s-1];
        r_mask[s] <= r_mask[s-1];
        r_dat[s]  <= r_dat[s-1];
      end
    end
  end

  assign o_vld  = r_vld[DEPTH-1];
  assign o_mask = r_mask[DEPTH-1];
  assign o_dat  = r_dat[DEPTH-1];

endmodule

// File: rtl/tb_sram_model_pipelined.sv
// Asynchronous SRAM model on the design clock: byte lanes, READ_LATENCY-deep read return,
// sequential power-on clear, saturating access counters and a sticky protocol-error flag.
module tb_sram_model_pipelined
  import tb_sram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 18,
  parameter int DATA_WIDTH     = 16,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                             Clock_50,
  input  logic                             Resetn,
  inout  wire  [DATA_WIDTH-1:0]            SRAM_data_io,
  input  logic [ADDR_WIDTH-1:0]            SRAM_address,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0] SRAM_BE_N,
  input  logic                             SRAM_WE_N,
  input  logic                             SRAM_CE_N,
  input  logic                             SRAM_OE_N,
  output logic                             Init_done,
  output logic [COUNT_WIDTH-1:0]           Write_count,
  output logic [COUNT_WIDTH-1:0]           Read_count,
  output logic                             Access_error
);

  localparam int BYTE_LANES = DATA_WIDTH / LANE_WIDTH;

  logic [DATA_WIDTH-1:0]  r_mem [2**ADDR_WIDTH];
  sram_state_t            r_state;
  logic                   r_init_done;
  logic [ADDR_WIDTH-1:0]  r_clr_ptr;
  logic [COUNT_WIDTH-1:0] r_wr_cnt;
  logic [COUNT_WIDTH-1:0] r_rd_cnt;
  logic                   r_err;

  logic                   w_ready;
  logic                   w_access;
  logic                   w_wr;
  logic                   w_rd;
  logic [BYTE_LANES-1:0]  w_lanes;
  logic                   w_wr_ok;
  logic                   w_rd_ok;
  logic                   w_bad;
  logic [DATA_WIDTH-1:0]  w_cur_word;
  logic [DATA_WIDTH-1:0]  w_wr_word;
  logic                   w_head_vld;
  logic [BYTE_LANES-1:0]  w_head_mask;
  logic [DATA_WIDTH-1:0]  w_head_dat;
  logic                   w_bus_en;

  assign w_ready    = (r_state == S_READY);
  assign w_wr       = !SRAM_CE_N && !SRAM_WE_N;
  assign w_rd       = !SRAM_CE_N && SRAM_WE_N && !SRAM_OE_N;
  assign w_access   = w_wr || w_rd;
  assign w_lanes    = ~SRAM_BE_N;
  assign w_wr_ok    = w_wr && w_ready && (|w_lanes);
  assign w_rd_ok    = w_rd && w_ready && (|w_lanes);
  // Early accesses and lane-less accesses are both dropped and flagged.
  assign w_bad      = w_access && (!w_ready || !(|w_lanes));
  assign w_cur_word = r_mem[SRAM_address];
  assign w_bus_en   = w_head_vld && w_rd;

  for (genvar g = 0; g < BYTE_LANES; g++) begin : g_lane
    assign w_wr_word[g*LANE_WIDTH +: LANE_WIDTH] = w_lanes[g] ? SRAM_data_io[g*LANE_WIDTH +: LANE_WIDTH]
                                                              : w_cur_word[g*LANE_WIDTH +: LANE_WIDTH];
    assign SRAM_data_io[g*LANE_WIDTH +: LANE_WIDTH] = (w_bus_en && w_head_mask[g])
                                                      ? w_head_dat[g*LANE_WIDTH +: LANE_WIDTH]
                                                      : {LANE_WIDTH{1'bz}};
  end

  always_ff @(posedge Clock_50) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_clr_ptr] <= '0;
    end else if (w_wr_ok) begin
      r_mem[SRAM_address] <= w_wr_word;
    end
  end

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_state     <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
      r_init_done <= (CLEAR_ON_RESET == 0);
      r_clr_ptr   <= '0;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_err       <= 1'b0;
    end else begin
      if (r_state == S_CLEAR) begin
        r_clr_ptr <= r_clr_ptr + ADDR_WIDTH'(1);
        if (&r_clr_ptr) begin
          r_state     <= S_READY;
          r_init_done <= 1'b1;
        end
      end
      if (w_wr_ok) r_wr_cnt <= sat_inc(r_wr_cnt);
      if (w_rd_ok) r_rd_cnt <= sat_inc(r_rd_cnt);
      if (w_bad)   r_err    <= 1'b1;
    end
  end

  tb_sram_read_pipe #(
    .DEPTH (READ_LATENCY),
    .LANES (BYTE_LANES)
  ) u_read_pipe (
    .i_clk   (Clock_50),
    .i_rst_n (Resetn),
    .i_vld   (w_rd_ok),
    .i_mask  (w_lanes),
    .i_dat   (w_cur_word),
    .o_vld   (w_head_vld),
    .o_mask  (w_head_mask),
    .o_dat   (w_head_dat)
  );

  assign Init_done    = r_init_done;
  assign Write_count  = r_wr_cnt;
  assign Read_count   = r_rd_cnt;
  assign Access_error = r_err;

endmodule

// File: tb/tb_tb_sram_model_pipelined.sv
// Directed bench: instance A (16 words, latency 3, clear on reset), instance B (latency 1, retain).
// Buses are pulled up so an undriven lane reads as all ones.
module tb_tb_sram_model_pipelined;

  logic core_clk = 1'b0;
  logic arst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 core_clk = ~core_clk;

  logic [3:0]  a_addr, b_addr;
  logic [1:0]  a_be_n, b_be_n;
  logic        a_we_n, a_ce_n, a_oe_n, b_we_n, b_ce_n, b_oe_n;
  logic [15:0] a_drv, b_drv;
  logic        a_drv_en, b_drv_en;
  wire  [15:0] a_bus, b_bus;
  logic        a_init, b_init, a_err, b_err;
  logic [31:0] a_wcnt, a_rcnt, b_wcnt, b_rcnt;
  logic [15:0] model [16];

  assign a_bus = a_drv_en ? a_drv : 16'hzzzz;
  assign b_bus = b_drv_en ? b_drv : 16'hzzzz;
  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup (a_bus[g]);
    pullup (b_bus[g]);
  end

  tb_sram_model_pipelined #(
    .ADDR_WIDTH(4), .DATA_WIDTH(16), .READ_LATENCY(3), .CLEAR_ON_RESET(1)
  ) u_dut_a (
    .Clock_50(core_clk), .Resetn(arst_n), .SRAM_data_io(a_bus), .SRAM_address(a_addr),
    .SRAM_BE_N(a_be_n), .SRAM_WE_N(a_we_n), .SRAM_CE_N(a_ce_n), .SRAM_OE_N(a_oe_n),
    .Init_done(a_init), .Write_count(a_wcnt), .Read_count(a_rcnt), .Access_error(a_err)
  );

  tb_sram_model_pipelined #(
    .ADDR_WIDTH(4), .DATA_WIDTH(16), .READ_LATENCY(1), .CLEAR_ON_RESET(0)
  ) u_dut_b (
    .Clock_50(core_clk), .Resetn(arst_n), .SRAM_data_io(b_bus), .SRAM_address(b_addr),
    .SRAM_BE_N(b_be_n), .SRAM_WE_N(b_we_n), .SRAM_CE_N(b_ce_n), .SRAM_OE_N(b_oe_n),
    .Init_done(b_init), .Write_count(b_wcnt), .Read_count(b_rcnt), .Access_error(b_err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  task automatic a_idle();
    a_ce_n = 1'b1; a_we_n = 1'b1; a_oe_n = 1'b1; a_be_n = 2'b11; a_drv_en = 1'b0;
  endtask

  task automatic b_idle();
    b_ce_n = 1'b1; b_we_n = 1'b1; b_oe_n = 1'b1; b_be_n = 2'b11; b_drv_en = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    a_addr = a; a_drv = d; a_drv_en = 1'b1; a_be_n = be;
    a_ce_n = 1'b0; a_we_n = 1'b0; a_oe_n = 1'b1;
    tick();
  endtask

  // Streams n reads from a0 upward; head data appears two edges after each sample.
  task automatic rd_stream(input logic [3:0] a0, input int n, input logic [1:0] be);
    logic [15:0] exp;
    logic [3:0]  a;
    a_idle();
    repeat (3) tick();
    a_addr = a0; a_be_n = be; a_ce_n = 1'b0; a_we_n = 1'b1; a_oe_n = 1'b0;
    for (int i = 0; i < n + 2; i++) begin
      tick();
      if (i + 1 < n) a_addr = a0 + 4'(i + 1);
      #1;
      if (i < 2) begin
        check_val("rd_lead_z", 32'(a_bus), 32'h0000_FFFF);
      end else begin
        a   = a0 + 4'(i - 2);
        exp = model[a];
        if (be[0]) exp[7:0]  = 8'hFF;
        if (be[1]) exp[15:8] = 8'hFF;
        check_val("rd_data", 32'(a_bus), 32'(exp));
      end
    end
    a_idle();
  endtask

  task automatic release_reset();
    @(negedge core_clk);
    arst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    arst_n = 1'b0;
    a_addr = '0; b_addr = '0; a_drv = '0; b_drv = '0;
    a_idle();
    b_idle();
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    repeat (3) tick();

    check_val("rst_a_init", 32'(a_init), 32'd0);
    check_val("rst_b_init", 32'(b_init), 32'd1);
    check_val("rst_a_wcnt", a_wcnt, 32'd0);
    check_val("rst_a_rcnt", a_rcnt, 32'd0);
    check_val("rst_a_err", 32'(a_err), 32'd0);
    check_val("rst_a_bus", 32'(a_bus), 32'h0000_FFFF);

    release_reset();
    repeat (15) tick();
    check_val("clr_init_e15", 32'(a_init), 32'd0);
    tick();
    check_val("clr_init_e16", 32'(a_init), 32'd1);

    rd_stream(4'd0, 16, 2'b00);

    wr(4'd3, 16'hABCD, 2'b00);
    wr(4'd3, 16'h1299, 2'b01);
    model[3] = 16'h12CD;
    rd_stream(4'd3, 1, 2'b00);
    rd_stream(4'd3, 1, 2'b10);

    wr(4'd5, 16'h55AA, 2'b00);
    wr(4'd6, 16'h1234, 2'b00);
    wr(4'd7, 16'hBEEF, 2'b00);
    wr(4'd8, 16'h0F0F, 2'b00);
    model[5] = 16'h55AA; model[6] = 16'h1234; model[7] = 16'hBEEF; model[8] = 16'h0F0F;
    rd_stream(4'd5, 4, 2'b00);
    wr(4'd6, 16'h9977, 2'b10);
    model[6] = 16'h1277;
    rd_stream(4'd6, 1, 2'b00);
    check_val("err_clean", 32'(a_err), 32'd0);

    b_addr = 4'd2; b_drv = 16'hC3A5; b_drv_en = 1'b1; b_be_n = 2'b00;
    b_ce_n = 1'b0; b_we_n = 1'b0; b_oe_n = 1'b1;
    tick();
    b_drv_en = 1'b0; b_we_n = 1'b1; b_oe_n = 1'b0;
    #1;
    check_val("b_lead_z", 32'(b_bus), 32'h0000_FFFF);
    tick();
    check_val("b_lat1_data", 32'(b_bus), 32'h0000_C3A5);
    b_idle();
    #1;
    check_val("b_oe_off_z", 32'(b_bus), 32'h0000_FFFF);
    check_val("b_wcnt", b_wcnt, 32'd1);
    check_val("b_rcnt", b_rcnt, 32'd1);

    // Write attempted while the clear engine is still running.
    arst_n = 1'b0;
    a_idle();
    repeat (2) tick();
    release_reset();
    repeat (3) tick();
    wr(4'd0, 16'hA5A5, 2'b00);
    a_idle();
    for (int t = 0; t < 40 && !a_init; t++) tick();
    check_val("early_init", 32'(a_init), 32'd1);
    check_val("early_wcnt", a_wcnt, 32'd0);
    check_val("early_err", 32'(a_err), 32'd1);
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    rd_stream(4'd0, 1, 2'b00);

    arst_n = 1'b0;
    a_idle();
    repeat (2) tick();
    release_reset();
    repeat (16) tick();
    check_val("cnt_init", 32'(a_init), 32'd1);
    for (int i = 0; i < 10; i++) begin
      wr(4'(i), 16'hC000 + 16'(i), 2'b00);
      model[i] = 16'hC000 + 16'(i);
    end
    a_drv_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      a_addr = 4'(i); a_be_n = 2'b00; a_ce_n = 1'b0; a_we_n = 1'b1; a_oe_n = 1'b0;
      tick();
    end
    check_val("cnt_err_pre", 32'(a_err), 32'd0);
    wr(4'd0, 16'h7777, 2'b11);
    a_idle();
    #1;
    check_val("cnt_wcnt", a_wcnt, 32'd10);
    check_val("cnt_rcnt", a_rcnt, 32'd7);
    check_val("cnt_err", 32'(a_err), 32'd1);
    rd_stream(4'd0, 3, 2'b00);

    b_addr = 4'd2; b_be_n = 2'b00; b_ce_n = 1'b0; b_we_n = 1'b1; b_oe_n = 1'b0;
    tick();
    check_val("b_retain", 32'(b_bus), 32'h0000_C3A5);
    b_idle();
    #1;
    check_val("b_rcnt_pre", b_rcnt, 32'd1);

    arst_n = 1'b0;
    repeat (2) tick();
    release_reset();
    repeat (8) tick();
    arst_n = 1'b0;
    #1;
    check_val("mid_init", 32'(a_init), 32'd0);
    check_val("mid_wcnt", a_wcnt, 32'd0);
    check_val("mid_rcnt", a_rcnt, 32'd0);
    check_val("mid_err", 32'(a_err), 32'd0);
    check_val("mid_b_rcnt", b_rcnt, 32'd0);
    repeat (2) tick();
    release_reset();
    repeat (15) tick();
    check_val("mid_init_e15", 32'(a_init), 32'd0);
    tick();
    check_val("mid_init_e16", 32'(a_init), 32'd1);
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    rd_stream(4'd0, 16, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
